// File: rtl/rf_port_scheduler_pkg.sv
// Shared constants for the register-file update-port scheduler:
// data/index widths, write-kind encodings and scheduler state encoding.
package rf_port_scheduler_pkg;

  localparam int ROB_ID_W_DEF = 4;
  localparam int DATA_W       = 32;
  localparam int REG_W        = 5;

  localparam logic WR_KIND_COMMIT = 1'b0;
  localparam logic WR_KIND_RENAME = 1'b1;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t ST_RUN   = 2'd0;
  localparam sched_state_t ST_DRAIN = 2'd1;
  localparam sched_state_t ST_CLEAR = 2'd2;

endpackage

// File: rtl/rf_port_scheduler_if.sv
// Bundle of the rename, commit and register-file update signals around the
// scheduler. The scheduler connects through the slave modport.
interface rf_port_scheduler_if
  import rf_port_scheduler_pkg::*;
#(
  parameter int ROB_ID_W = ROB_ID_W_DEF
);
  logic                ID_valid;
  logic [REG_W-1:0]    ID_rd;
  logic [ROB_ID_W-1:0] ID_rob_id;
  logic                ID_ready;

  logic                ROB_valid;
  logic [REG_W-1:0]    ROB_rd;
  logic [DATA_W-1:0]   ROB_value;
  logic [ROB_ID_W-1:0] ROB_rob_id;
  logic                ROB_ready;
  logic                ROB_roll_back;

  logic                RF_wr_valid;
  logic                RF_wr_kind;
  logic [REG_W-1:0]    RF_wr_rd;
  logic [DATA_W-1:0]   RF_wr_value;
  logic [ROB_ID_W-1:0] RF_wr_rob_id;
  logic                RF_clear_all;
  logic                busy;

  modport master (
    output ID_valid, ID_rd, ID_rob_id,
    output ROB_valid, ROB_rd, ROB_value, ROB_rob_id, ROB_roll_back,
    input  ID_ready, ROB_ready,
    input  RF_wr_valid, RF_wr_kind, RF_wr_rd, RF_wr_value, RF_wr_rob_id,
    input  RF_clear_all, busy
  );

  modport slave (
    input  ID_valid, ID_rd, ID_rob_id,
    input  ROB_valid, ROB_rd, ROB_value, ROB_rob_id, ROB_roll_back,
    output ID_ready, ROB_ready,
    output RF_wr_valid, RF_wr_kind, RF_wr_rd, RF_wr_value, RF_wr_rob_id,
    output RF_clear_all, busy
  );

endinterface

// File: rtl/rf_port_scheduler_commit_fifo.sv
// rf_commit_fifo: synchronous FIFO holding committed writes until the update
// port is granted to them. Pointers carry one extra wrap bit so full and
// empty are told apart by the MSB alone.
module rf_commit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout    = mem[rptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  // a push into a full FIFO is legal only when the head leaves the same cycle
  assign do_push = push && (!full || do_pop);

  // pointer advance on accepted push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // storage write; contents need no reset since empty masks them
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rf_port_scheduler.sv
// rf_port_scheduler: owns the single register-file update port. Each cycle
// it grants either a decoder rename claim or a buffered ROB commit, with
// commits forced after STARVE_LIMIT consecutive renames. A rollback drains
// the commit FIFO and then clears all busy tags.
// Optional statistics counters are built when RF_SCHED_STATS_EN is defined.
//
//   state | meaning
//   RUN   | normal arbitration between renames and commits
//   DRAIN | rollback seen; pop remaining commits, no new requests
//   CLEAR | one-cycle clear-all of busy tags, then back to RUN
module rf_port_scheduler
  import rf_port_scheduler_pkg::*;
#(
  parameter int COMMIT_DEPTH = 4,
  parameter int ROB_ID_W     = ROB_ID_W_DEF,
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
`ifdef RF_SCHED_STATS_EN
  output logic [31:0] cnt_rename,
  output logic [31:0] cnt_commit,
  output logic [31:0] cnt_stall,
`endif
  rf_port_scheduler_if.slave sch
);
  localparam int ENTRY_W  = REG_W + DATA_W + ROB_ID_W;
  localparam int STARVE_W = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

  sched_state_t        state;
  sched_state_t        state_nxt;
  logic [STARVE_W-1:0] starve;
  logic                full;
  logic                empty;
  logic [ENTRY_W-1:0]  head;
  logic                run;
  logic                force_commit;
  logic                grant_rename;
  logic                pop;
  logic                push;

  logic                wr_valid_q;
  logic                wr_kind_q;
  logic [REG_W-1:0]    wr_rd_q;
  logic [DATA_W-1:0]   wr_value_q;
  logic [ROB_ID_W-1:0] wr_rob_id_q;

  assign run          = (state == ST_RUN);
  assign force_commit = full || (!empty && (starve == STARVE_MAX));

  // rename readiness never looks at ID_valid, so the decoder sees a stable ready
  assign sch.ID_ready = rst && rdy && run && !sch.ROB_roll_back && !force_commit;
  assign grant_rename = sch.ID_valid && sch.ID_ready;
  assign sch.ROB_ready = rdy && run && (!full || pop);
  assign push         = sch.ROB_valid && sch.ROB_ready;

  // commit pop: forced, or whenever no rename takes the port; every cycle in DRAIN
  always_comb begin
    pop = 1'b0;
    if (rdy && !empty) begin
      if (state == ST_RUN)        pop = force_commit || !grant_rename;
      else if (state == ST_DRAIN) pop = 1'b1;
    end
  end

  // next-state: rollback is only honoured in RUN
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (sch.ROB_roll_back) state_nxt = ST_DRAIN;
      ST_DRAIN: if (empty) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  rf_commit_fifo #(
    .DEPTH (COMMIT_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_commit_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .din   ({sch.ROB_rd, sch.ROB_value, sch.ROB_rob_id}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // state, starve counter and registered update-port payload; rdy=0 freezes all
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RUN;
      starve      <= '0;
      wr_valid_q  <= 1'b0;
      wr_kind_q   <= WR_KIND_COMMIT;
      wr_rd_q     <= '0;
      wr_value_q  <= '0;
      wr_rob_id_q <= '0;
    end else if (rdy) begin
      state <= state_nxt;
      if (pop || !run)   starve <= '0;
      else if (grant_rename) starve <= empty ? '0 : starve + STARVE_ONE;
      wr_valid_q <= pop || grant_rename;
      if (pop) begin
        wr_kind_q <= WR_KIND_COMMIT;
        {wr_rd_q, wr_value_q, wr_rob_id_q} <= head;
      end else if (grant_rename) begin
        wr_kind_q   <= WR_KIND_RENAME;
        wr_rd_q     <= sch.ID_rd;
        wr_value_q  <= '0;
        wr_rob_id_q <= sch.ID_rob_id;
      end
    end
  end

  // a held write stays hidden while frozen and shows once when rdy returns
  assign sch.RF_wr_valid  = wr_valid_q && rdy;
  assign sch.RF_wr_kind   = wr_kind_q;
  assign sch.RF_wr_rd     = wr_rd_q;
  assign sch.RF_wr_value  = wr_value_q;
  assign sch.RF_wr_rob_id = wr_rob_id_q;
  assign sch.RF_clear_all = (state == ST_CLEAR) && rdy;
  assign sch.busy         = !run;

`ifdef RF_SCHED_STATS_EN
  // saturating event counters, cleared by reset only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_rename <= '0;
      cnt_commit <= '0;
      cnt_stall  <= '0;
    end else if (rdy) begin
      if (grant_rename && (cnt_rename != '1)) cnt_rename <= cnt_rename + 32'd1;
      if (pop && (cnt_commit != '1))          cnt_commit <= cnt_commit + 32'd1;
      if (sch.ID_valid && !sch.ID_ready && (cnt_stall != '1))
        cnt_stall <= cnt_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_port_scheduler.sv
// Directed bench for rf_port_scheduler: a per-cycle vector table covering
// commit latency, starvation forcing, full FIFO and rollback, followed by
// hand-written sequences for freeze during DRAIN and async reset in DRAIN.
module tb_rf_port_scheduler;

  logic clk;
  logic rst;
  logic rdy;
  int   tests;
  int   failed;

  rf_port_scheduler_if #(.ROB_ID_W(4)) ifc ();

`ifdef RF_SCHED_STATS_EN
  logic [31:0] cnt_rename;
  logic [31:0] cnt_commit;
  logic [31:0] cnt_stall;
`endif

  rf_port_scheduler #(
    .COMMIT_DEPTH (4),
    .ROB_ID_W     (4),
    .STARVE_LIMIT (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
`ifdef RF_SCHED_STATS_EN
    .cnt_rename (cnt_rename),
    .cnt_commit (cnt_commit),
    .cnt_stall  (cnt_stall),
`endif
    .sch        (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdy, idv, id_rd, id_rob, robv, rob_rd, rob_val, rob_id, roll;
    logic [31:0] e_idr, e_robr, e_wv, e_kind, e_rd, e_val, e_id, e_clr, e_busy;
  } vec_t;

  function automatic vec_t mk(
    input logic [31:0] rdy_i, idv, id_rd, id_rob, robv, rob_rd, rob_val, rob_id, roll,
    input logic [31:0] e_idr, e_robr, e_wv, e_kind, e_rd, e_val, e_id, e_clr, e_busy);
    vec_t v;
    v.rdy = rdy_i; v.idv = idv; v.id_rd = id_rd; v.id_rob = id_rob;
    v.robv = robv; v.rob_rd = rob_rd; v.rob_val = rob_val; v.rob_id = rob_id;
    v.roll = roll; v.e_idr = e_idr; v.e_robr = e_robr; v.e_wv = e_wv;
    v.e_kind = e_kind; v.e_rd = e_rd; v.e_val = e_val; v.e_id = e_id;
    v.e_clr = e_clr; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    ifc.ID_valid = 1'b0; ifc.ID_rd = '0; ifc.ID_rob_id = '0;
    ifc.ROB_valid = 1'b0; ifc.ROB_rd = '0; ifc.ROB_value = '0;
    ifc.ROB_rob_id = '0; ifc.ROB_roll_back = 1'b0;
  endtask

  // drive one cycle's inputs after the edge, check outputs at the falling edge
  task automatic step(input string tag, input vec_t v);
    @(posedge clk);
    #1;
    rdy = v.rdy[0];
    ifc.ID_valid = v.idv[0]; ifc.ID_rd = 5'(v.id_rd); ifc.ID_rob_id = 4'(v.id_rob);
    ifc.ROB_valid = v.robv[0]; ifc.ROB_rd = 5'(v.rob_rd); ifc.ROB_value = v.rob_val;
    ifc.ROB_rob_id = 4'(v.rob_id); ifc.ROB_roll_back = v.roll[0];
    @(negedge clk);
    chk({tag, " ID_ready"},     32'(ifc.ID_ready),     v.e_idr);
    chk({tag, " ROB_ready"},    32'(ifc.ROB_ready),    v.e_robr);
    chk({tag, " RF_wr_valid"},  32'(ifc.RF_wr_valid),  v.e_wv);
    chk({tag, " RF_clear_all"}, 32'(ifc.RF_clear_all), v.e_clr);
    chk({tag, " busy"},         32'(ifc.busy),         v.e_busy);
    if (v.e_wv != 0) begin
      chk({tag, " RF_wr_kind"},   32'(ifc.RF_wr_kind),   v.e_kind);
      chk({tag, " RF_wr_rd"},     32'(ifc.RF_wr_rd),     v.e_rd);
      chk({tag, " RF_wr_rob_id"}, 32'(ifc.RF_wr_rob_id), v.e_id);
      if (v.e_kind == 0) chk({tag, " RF_wr_value"}, ifc.RF_wr_value, v.e_val);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " RF_wr_valid"},  32'(ifc.RF_wr_valid),  0);
    chk({tag, " RF_wr_kind"},   32'(ifc.RF_wr_kind),   0);
    chk({tag, " RF_wr_rd"},     32'(ifc.RF_wr_rd),     0);
    chk({tag, " RF_wr_value"},  ifc.RF_wr_value,       0);
    chk({tag, " RF_wr_rob_id"}, 32'(ifc.RF_wr_rob_id), 0);
    chk({tag, " RF_clear_all"}, 32'(ifc.RF_clear_all), 0);
    chk({tag, " ROB_ready"},    32'(ifc.ROB_ready),    1);
    chk({tag, " ID_ready"},     32'(ifc.ID_ready),     0);
    chk({tag, " busy"},         32'(ifc.busy),         0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl [27];
  vec_t idle_v;

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b0;
    rdy = 1'b1;
    set_idle();

    //           rdy idv rd  rob robv rd val            id roll | idr robr wv kd rd val            id clr bsy
    tbl[0]  = mk(1, 0, 0, 0,  1, 5,  32'hDEADBEEF, 2,  0,  1, 1,  0, 0, 0,  0,            0,  0, 0);
    tbl[1]  = mk(1, 0, 0, 0,  0, 0,  0,            0,  0,  1, 1,  0, 0, 0,  0,            0,  0, 0);
    tbl[2]  = mk(1, 0, 0, 0,  0, 0,  0,            0,  0,  1, 1,  1, 0, 5,  32'hDEADBEEF, 2,  0, 0);
    tbl[3]  = mk(1, 1, 1, 8,  1, 7,  32'h11111111, 3,  0,  1, 1,  0, 0, 0,  0,            0,  0, 0);
    tbl[4]  = mk(1, 1, 2, 9,  0, 0,  0,            0,  0,  1, 1,  1, 1, 1,  0,            8,  0, 0);
    tbl[5]  = mk(1, 1, 3, 10, 0, 0,  0,            0,  0,  1, 1,  1, 1, 2,  0,            9,  0, 0);
    tbl[6]  = mk(1, 1, 4, 11, 0, 0,  0,            0,  0,  1, 1,  1, 1, 3,  0,            10, 0, 0);
    tbl[7]  = mk(1, 1, 5, 12, 0, 0,  0,            0,  0,  0, 1,  1, 1, 4,  0,            11, 0, 0);
    tbl[8]  = mk(1, 1, 5, 12, 0, 0,  0,            0,  0,  1, 1,  1, 0, 7,  32'h11111111, 3,  0, 0);
    tbl[9]  = mk(1, 0, 0, 0,  0, 0,  0,            0,  0,  1, 1,  1, 1, 5,  0,            12, 0, 0);
    tbl[10] = mk(1, 1, 20, 0, 1, 10, 32'hA0A0A0A0, 1,  0,  1, 1,  0, 0, 0,  0,            0,  0, 0);
    tbl[11] = mk(1, 1, 21, 1, 1, 11, 32'hB1B1B1B1, 5,  0,  1, 1,  1, 1, 20, 0,            0,  0, 0);
    tbl[12] = mk(1, 1, 22, 2, 1, 12, 32'hC2C2C2C2, 6,  0,  1, 1,  1, 1, 21, 0,            1,  0, 0);
    tbl[13] = mk(1, 1, 23, 3, 1, 13, 32'hD3D3D3D3, 7,  0,  1, 1,  1, 1, 22, 0,            2,  0, 0);
    tbl[14] = mk(0, 1, 24, 4, 1, 14, 32'hE4E4E4E4, 8,  0,  0, 0,  0, 0, 0,  0,            0,  0, 0);
    tbl[15] = mk(1, 1, 24, 4, 1, 14, 32'hE4E4E4E4, 8,  0,  0, 1,  1, 1, 23, 0,            3,  0, 0);
    tbl[16] = mk(1, 1, 24, 4, 0, 0,  0,            0,  0,  0, 1,  1, 0, 10, 32'hA0A0A0A0, 1,  0, 0);
    tbl[17] = mk(1, 1, 24, 4, 0, 0,  0,            0,  0,  1, 1,  1, 0, 11, 32'hB1B1B1B1, 5,  0, 0);
    tbl[18] = mk(1, 0, 0, 0,  0, 0,  0,            0,  0,  1, 1,  1, 1, 24, 0,            4,  0, 0);
    tbl[19] = mk(1, 1, 25, 5, 1, 15, 32'hF5F5F5F5, 9,  0,  1, 1,  1, 0, 12, 32'hC2C2C2C2, 6,  0, 0);
    tbl[20] = mk(1, 1, 26, 6, 1, 16, 32'h16161616, 10, 1,  0, 1,  1, 1, 25, 0,            5,  0, 0);
    tbl[21] = mk(1, 1, 26, 6, 1, 17, 32'h17171717, 11, 0,  0, 0,  1, 0, 13, 32'hD3D3D3D3, 7,  0, 1);
    tbl[22] = mk(1, 1, 26, 6, 0, 0,  0,            0,  1,  0, 0,  1, 0, 14, 32'hE4E4E4E4, 8,  0, 1);
    tbl[23] = mk(1, 0, 0, 0,  0, 0,  0,            0,  0,  0, 0,  1, 0, 15, 32'hF5F5F5F5, 9,  0, 1);
    tbl[24] = mk(1, 0, 0, 0,  0, 0,  0,            0,  0,  0, 0,  1, 0, 16, 32'h16161616, 10, 0, 1);
    tbl[25] = mk(1, 0, 0, 0,  0, 0,  0,            0,  1,  0, 0,  0, 0, 0,  0,            0,  1, 1);
    tbl[26] = mk(1, 0, 0, 0,  0, 0,  0,            0,  0,  1, 1,  0, 0, 0,  0,            0,  0, 0);

    idle_v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b1;

    for (int i = 0; i < 27; i++) step($sformatf("v%0d", i), tbl[i]);

    // rdy low for three cycles in the middle of a drain
    step("s0",  mk(1, 1, 30, 12, 1, 1, 32'h1001, 1, 0,  1, 1,  0, 0, 0,  0,         0,  0, 0));
    step("s1",  mk(1, 1, 31, 13, 1, 2, 32'h1002, 2, 0,  1, 1,  1, 1, 30, 0,         12, 0, 0));
    step("s2",  mk(1, 1, 29, 14, 1, 3, 32'h1003, 3, 1,  0, 1,  1, 1, 31, 0,         13, 0, 0));
    step("s3",  mk(1, 0, 0,  0,  0, 0, 0,        0, 0,  0, 0,  1, 0, 1,  32'h1001,  1,  0, 1));
    for (int k = 4; k < 7; k++)
      step($sformatf("s%0d", k), mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 1));
    step("s7",  mk(1, 0, 0,  0,  0, 0, 0,        0, 0,  0, 0,  1, 0, 2,  32'h1002,  2,  0, 1));
    step("s8",  mk(1, 0, 0,  0,  0, 0, 0,        0, 0,  0, 0,  1, 0, 3,  32'h1003,  3,  0, 1));
    step("s9",  mk(1, 0, 0,  0,  0, 0, 0,        0, 0,  0, 0,  0, 0, 0,  0,         0,  1, 1));
    step("s10", idle_v);

    // asynchronous reset while a commit is still queued in DRAIN
    step("r0",  mk(1, 1, 6, 0,  1, 4, 32'h2004, 4, 0,  1, 1,  0, 0, 0, 0,         0,  0, 0));
    step("r1",  mk(1, 1, 7, 1,  1, 5, 32'h2005, 5, 0,  1, 1,  1, 1, 6, 0,         0,  0, 0));
    step("r2",  mk(1, 1, 8, 2,  0, 0, 0,        0, 1,  0, 1,  1, 1, 7, 0,         1,  0, 0));
    step("r3",  mk(1, 0, 0, 0,  0, 0, 0,        0, 0,  0, 0,  1, 0, 4, 32'h2004,  4,  0, 1));
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) step($sformatf("post_rst%0d", k), idle_v);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
